golden_nonce_queue: RTL
=======================

# golden_nonce_queue

Buffers golden nonces reported by the hasher array and feeds them one at a time to `serial_transmit` over its `send`/`busy`/`word` handshake. Nonces can arrive back-to-back while a 4-byte UART transfer takes milliseconds, so without this block results would be lost. The queue flushes stale results whenever `serial_receive` toggles `load_flag` to signal new work. It also counts nonces dropped on overflow so the host can detect them.

## Interface
- `DEPTH`, default 8. FIFO entries; must be a power of two and at least 2.
- `DUP_FILTER`, default 1. When 1, a pushed nonce equal to the most recently accepted nonce is ignored.
- `clk` in 1. Single clock; all logic is on the rising edge.
- `reset` in 1. Synchronous, active-high.
- `nonce_valid` in 1. One-cycle strobe: `nonce` holds a golden nonce.
- `nonce` in 32. Nonce value, qualified by `nonce_valid`.
- `load_flag` in 1. From `serial_receive`; toggles once per new work load.
- `tx_busy` in 1. `busy` from `serial_transmit`.
- `tx_send` out 1. `send` to `serial_transmit`; a one-cycle pulse.
- `tx_word` out 32. `word` to `serial_transmit`; held stable from the `tx_send` pulse until the next pulse.
- `pending` out $clog2(DEPTH)+1. Current FIFO occupancy.
- `dropped` out 8. Saturating count of nonces lost to overflow.

## Operation
- **Push:** occurs when `nonce_valid`=1 and no flush is pending this cycle.
  - With `DUP_FILTER`=1, a nonce equal to the last accepted value (held in a register, cleared by reset or flush) is discarded silently and not counted.
  - Full queue with no pop this cycle: the nonce is discarded and `dropped` increments, saturating at 255.
  - Full queue with a pop in the same cycle: the push is accepted.
- **Flush:** `load_flag` is compared against a registered copy each cycle; a difference means a flush.
  - Flush clears occupancy and the duplicate register.
  - A push in the same cycle as a flush is discarded and not counted.
  - A transfer already handed to `serial_transmit` is unaffected. The FSM continues its current state.
  - `dropped` is not cleared by flush.
- **Transmit FSM:** three states.
  - IDLE: if the queue is non-empty and `tx_busy`=0, register `tx_send`<=1, register `tx_word`<=head, pop the head, and go to ACK.
  - ACK: `tx_send`<=0. Go to DRAIN when `tx_busy`=1, or after 2 cycles in ACK as a guard against a missed ack.
  - DRAIN: return to IDLE when `tx_busy`=0.
- **Pop and flush together:** if a pop and a flush occur in the same cycle, the popped word is still sent.
- **Pointers:** width $clog2(DEPTH) and wrap naturally. Occupancy is tracked separately, so full (=`DEPTH`) and empty (=0) are unambiguous.

## Timing
- **Reset:**
  - Outputs: `tx_send`=0, `tx_word`=0, `pending`=0, `dropped`=0.
  - Internal: FSM in IDLE, duplicate register invalid.
  - The `load_flag` copy is loaded from `load_flag`, so no flush fires on exit from reset.
  - Reset mid-transfer abandons the handshake; `serial_transmit` finishes its byte stream on its own.
- **Push to send latency:** with an empty queue in IDLE, `nonce_valid` high in cycle 0 gives `pending`=1 in cycle 1 and `tx_send`=1 in cycle 2.
- **`pending` update:** reflects push, pop and flush the cycle after the event.
- **Handshake:** `serial_transmit` latches `word` on the edge where `send`=1 and `busy`=0, then raises `busy` one cycle later. Sends are therefore at least 3 cycles apart plus the transfer time.
- **Throughput:** one nonce per transfer. The input accepts one nonce per cycle.

## Structure
- **Shared package `miner_pkg`:**
  - FSM state encoding: `GNQ_IDLE`=2'd0, `GNQ_ACK`=2'd1, `GNQ_DRAIN`=2'd2.
  - `NONCE_W`=32.
  - `DROP_W`=8.
- **Sub-module `nonce_fifo`:** synchronous single-clock FIFO with push, pop, flush, occupancy and a registered head. It holds the memory and pointers.
- **Top level:** holds the push qualification (duplicate filter, overflow), flush detection, the FSM and the output registers.

## Test plan
- Reset, then push 0x12345678 with `tx_busy` held 0 → `tx_send` pulses exactly in cycle 2 and `tx_word`=0x12345678. After a model `serial_transmit` pulses `tx_busy` for 40 cycles, the FSM returns to IDLE and `pending`=0.
- `DEPTH`=8: push 10 distinct nonces on consecutive cycles while `tx_busy`=1 → `pending`=8 and `dropped`=2. After the busy periods end, the first 8 nonces are sent in order.
- Push 0xAAAA0001 twice back-to-back, then 0xAAAA0002, with `DUP_FILTER`=1 → only two sends occur (0001, then 0002) and `dropped`=0.
- Queue 3 nonces, let the first send start, then toggle `load_flag` → the in-flight word completes, `pending`=0 the next cycle, and no further `tx_send` occurs. A push in the flush cycle is ignored.
- Full queue with a pop and a push in the same cycle → the push is accepted, `pending` stays 8, `dropped` is unchanged. Then force 300 overflows → `dropped` saturates at 255.
- Hold `tx_busy`=0 permanently during ACK (no ack) → after 2 cycles the FSM reaches DRAIN, then IDLE, and the next queued nonce is sent.

Source files
------------

// File: rtl/miner_pkg.sv
// Shared types and constants for the miner datapath blocks.
package miner_pkg;

    localparam int unsigned NONCE_W = 32;
    localparam int unsigned DROP_W  = 8;

    typedef logic [NONCE_W-1:0] nonce_t;

    typedef enum logic [1:0] {
        GNQ_IDLE  = 2'd0,
        GNQ_ACK   = 2'd1,
        GNQ_DRAIN = 2'd2
    } gnq_state_t;

endpackage

// File: rtl/golden_nonce_queue_if.sv
// Nonce input, work-load flag and serial_transmit handshake of the golden nonce queue.
interface golden_nonce_queue_if
    import miner_pkg::*;
#(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              nonce_valid;
    nonce_t            nonce;
    logic              load_flag;
    logic              tx_busy;
    logic              tx_send;
    nonce_t            tx_word;
    logic [CNT_W-1:0]  pending;
    logic [DROP_W-1:0] dropped;

    modport master (
        output nonce_valid, nonce, load_flag, tx_busy,
        input  tx_send, tx_word, pending, dropped
    );

    modport slave (
        input  nonce_valid, nonce, load_flag, tx_busy,
        output tx_send, tx_word, pending, dropped
    );

endinterface

// File: rtl/nonce_fifo.sv
// Single-clock nonce FIFO with flush, occupancy count and a registered head word.
module nonce_fifo
    import miner_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  nonce_t                   din,
    output nonce_t                   head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    nonce_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next_c;

    assign rd_next_c = rd_ptr + PTR_W'(1);

    // Storage write; the caller never pushes into a full FIFO without a pop.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and head register; head follows the entry at rd_ptr.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_next_c;
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (pop) begin
                head <= (count == CNT_W'(1)) ? din : mem[rd_next_c];
            end else if (push && (count == '0)) begin
                head <= din;
            end
        end
    end

endmodule

// File: rtl/golden_nonce_queue.sv
// Buffers golden nonces and hands them one at a time to serial_transmit.
module golden_nonce_queue
    import miner_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter bit          DUP_FILTER = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    golden_nonce_queue_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    gnq_state_t        state;
    gnq_state_t        state_d;
    logic              ack_cnt;
    logic              ack_cnt_d;
    logic              tx_send_q;
    logic              send_d;
    nonce_t            tx_word_q;
    nonce_t            word_d;
    logic              load_flag_q;
    logic              dup_valid;
    nonce_t            last_nonce;
    logic [DROP_W-1:0] dropped_q;
    nonce_t            head;
    logic [CNT_W-1:0]  count;

    logic flush_c;
    logic dup_hit_c;
    logic push_req_c;
    logic full_c;
    logic push_c;
    logic drop_c;
    logic pop_c;

    nonce_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_c),
        .pop   (pop_c),
        .flush (flush_c),
        .din   (bus.nonce),
        .head  (head),
        .count (count)
    );

    // Push qualification: flush blocks, duplicates vanish, full without pop drops.
    always_comb begin
        flush_c    = (bus.load_flag != load_flag_q);
        dup_hit_c  = DUP_FILTER && dup_valid && (bus.nonce == last_nonce);
        push_req_c = bus.nonce_valid && !flush_c && !dup_hit_c;
        full_c     = (count == CNT_W'(DEPTH));
        push_c     = push_req_c && (!full_c || pop_c);
        drop_c     = push_req_c && full_c && !pop_c;
    end

    // Flush detection, duplicate register and saturating drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_flag_q <= bus.load_flag;
            dup_valid   <= 1'b0;
            last_nonce  <= '0;
            dropped_q   <= '0;
        end else begin
            load_flag_q <= bus.load_flag;
            if (flush_c) begin
                dup_valid <= 1'b0;
            end else if (push_c) begin
                dup_valid  <= 1'b1;
                last_nonce <= bus.nonce;
            end
            if (drop_c && (dropped_q != '1)) begin
                dropped_q <= dropped_q + DROP_W'(1);
            end
        end
    end

    // Transmit FSM next-state and output decode; ACK gives up after two cycles.
    always_comb begin
        state_d   = state;
        ack_cnt_d = ack_cnt;
        send_d    = 1'b0;
        word_d    = tx_word_q;
        pop_c     = 1'b0;
        case (state)
            GNQ_IDLE: begin
                if ((count != '0) && !bus.tx_busy) begin
                    send_d    = 1'b1;
                    word_d    = head;
                    pop_c     = 1'b1;
                    ack_cnt_d = 1'b0;
                    state_d   = GNQ_ACK;
                end
            end
            GNQ_ACK: begin
                if (bus.tx_busy || ack_cnt) begin
                    state_d = GNQ_DRAIN;
                end else begin
                    ack_cnt_d = 1'b1;
                end
            end
            GNQ_DRAIN: begin
                if (!bus.tx_busy) state_d = GNQ_IDLE;
            end
            default: state_d = GNQ_IDLE;
        endcase
    end

    // FSM state and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= GNQ_IDLE;
            ack_cnt   <= 1'b0;
            tx_send_q <= 1'b0;
            tx_word_q <= '0;
        end else begin
            state     <= state_d;
            ack_cnt   <= ack_cnt_d;
            tx_send_q <= send_d;
            tx_word_q <= word_d;
        end
    end

    assign bus.tx_send = tx_send_q;
    assign bus.tx_word = tx_word_q;
    assign bus.pending = count;
    assign bus.dropped = dropped_q;

endmodule
